frontend_issue_queue: RTL



---
 rtl/frontend_pkg.sv | 58 +++++
 rtl/instr_class_decode.sv | 84 ++++++++
 rtl/frontend_issue_queue.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/frontend_pkg.sv
// Shared types and MIPS classification constants for the frontend issue queue.
package frontend_pkg;

  localparam int MASK_W = 31;

  typedef logic [MASK_W-1:0] reg_mask_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    reg_mask_t   rmask;
    reg_mask_t   wmask;
    logic        is_branch;
    logic        is_load;
    logic        is_store;
  } entry_t;

  typedef enum logic [0:0] {
    ST_NORMAL = 1'b0,
    ST_BUBBLE = 1'b1
  } issue_state_t;

  localparam logic [5:0] OP_SPECIAL = 6'h00;
  localparam logic [5:0] OP_REGIMM  = 6'h01;
  localparam logic [5:0] OP_J       = 6'h02;
  localparam logic [5:0] OP_JAL     = 6'h03;
  localparam logic [5:0] OP_BEQ     = 6'h04;
  localparam logic [5:0] OP_BNE     = 6'h05;
  localparam logic [5:0] OP_BLEZ    = 6'h06;
  localparam logic [5:0] OP_BGTZ    = 6'h07;
  localparam logic [5:0] OP_LB      = 6'h20;
  localparam logic [5:0] OP_LH      = 6'h21;
  localparam logic [5:0] OP_LWL     = 6'h22;
  localparam logic [5:0] OP_LW      = 6'h23;
  localparam logic [5:0] OP_LBU     = 6'h24;
  localparam logic [5:0] OP_LHU     = 6'h25;
  localparam logic [5:0] OP_LWR     = 6'h26;
  localparam logic [5:0] OP_SB      = 6'h28;
  localparam logic [5:0] OP_SH      = 6'h29;
  localparam logic [5:0] OP_SWL     = 6'h2a;
  localparam logic [5:0] OP_SW      = 6'h2b;
  localparam logic [5:0] OP_SWR     = 6'h2e;
  localparam logic [5:0] FN_JR      = 6'h08;
  localparam logic [5:0] FN_JALR    = 6'h09;

  // GPR r maps to mask bit r-1; $0 never contributes a dependency.
  function automatic reg_mask_t reg_bit(input logic [4:0] r);
    reg_mask_t m;
    m = '0;
    if (r != 5'd0) begin
      m[r - 5'd1] = 1'b1;
    end else begin
      m = '0;
    end
    return m;
  endfunction

endpackage

// File: rtl/instr_class_decode.sv
// Classifies an instruction word into register read/write masks and
// branch/load/store flags; unknown opcodes conservatively read rs and rt.
module instr_class_decode
  import frontend_pkg::*;
(
  input  logic [31:0] instr,
  output reg_mask_t   rmask,
  output reg_mask_t   wmask,
  output logic        is_branch,
  output logic        is_load,
  output logic        is_store
);

  logic [5:0] op_s;
  logic [5:0] funct_s;
  logic [4:0] rs_s;
  logic [4:0] rt_s;
  logic [4:0] rd_s;

  assign op_s    = instr[31:26];
  assign rs_s    = instr[25:21];
  assign rt_s    = instr[20:16];
  assign rd_s    = instr[15:11];
  assign funct_s = instr[5:0];

  // Opcode classification into dependency masks and control flags.
  always_comb begin
    rmask     = '0;
    wmask     = '0;
    is_branch = 1'b0;
    is_load   = 1'b0;
    is_store  = 1'b0;
    case (op_s)
      OP_SPECIAL: begin
        rmask     = reg_bit(rs_s) | reg_bit(rt_s);
        wmask     = (funct_s == FN_JR) ? '0 : reg_bit(rd_s);
        is_branch = (funct_s == FN_JR) || (funct_s == FN_JALR);
      end
      OP_REGIMM: begin
        rmask     = reg_bit(rs_s);
        wmask     = rt_s[4] ? reg_bit(5'd31) : '0;
        is_branch = 1'b1;
      end
      OP_J: begin
        is_branch = 1'b1;
      end
      OP_JAL: begin
        wmask     = reg_bit(5'd31);
        is_branch = 1'b1;
      end
      OP_BEQ, OP_BNE: begin
        rmask     = reg_bit(rs_s) | reg_bit(rt_s);
        is_branch = 1'b1;
      end
      OP_BLEZ, OP_BGTZ: begin
        rmask     = reg_bit(rs_s);
        is_branch = 1'b1;
      end
      6'h08, 6'h09, 6'h0a, 6'h0b, 6'h0c, 6'h0d, 6'h0e, 6'h0f: begin
        rmask = reg_bit(rs_s);
        wmask = reg_bit(rt_s);
      end
      OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU: begin
        rmask   = reg_bit(rs_s);
        wmask   = reg_bit(rt_s);
        is_load = 1'b1;
      end
      // Partial-word loads merge into the old rt value.
      OP_LWL, OP_LWR: begin
        rmask   = reg_bit(rs_s) | reg_bit(rt_s);
        wmask   = reg_bit(rt_s);
        is_load = 1'b1;
      end
      OP_SB, OP_SH, OP_SWL, OP_SW, OP_SWR: begin
        rmask    = reg_bit(rs_s) | reg_bit(rt_s);
        is_store = 1'b1;
      end
      default: begin
        rmask = reg_bit(rs_s) | reg_bit(rt_s);
      end
    endcase
  end

endmodule

// File: rtl/frontend_issue_queue.sv
// Fetch-to-decode compacting issue queue with post-branch bubble insertion.
// Optional load hoisting within a head window is enabled by FRONTEND_HOIST_EN.
module frontend_issue_queue
  import frontend_pkg::*;
#(
  parameter  int DEPTH  = 4,
  parameter  int WINDOW = 2,
  localparam int CW     = $clog2(DEPTH + 1),
  localparam int IW     = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          flush,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [31:0]   in_pc,
  input  logic [31:0]   in_instr,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [31:0]   out_pc,
  output logic [31:0]   out_instr,
  output logic          out_nop,
  output logic          out_hoisted,
  output logic          pred_valid,
  output logic [31:0]   pred_pc,
  output logic [31:0]   pred_instr,
  output logic [CW-1:0] count
);

  entry_t       entry_r [DEPTH];
  entry_t       entry_nxt_s [DEPTH];
  logic [CW-1:0] count_r;
  logic [CW-1:0] count_nxt_s;
  logic [CW-1:0] count_shift_s;
  issue_state_t state_r;
  issue_state_t state_nxt_s;

  entry_t        new_entry_s;
  entry_t        head_s;
  entry_t        pred_entry_s;
  logic [IW-1:0] sel_idx_s;
  logic [IW-1:0] pred_idx_s;
  logic          hoist_s;
  logic          issue_s;
  logic          enq_s;

  assign new_entry_s.pc    = in_pc;
  assign new_entry_s.instr = in_instr;

  instr_class_decode u_decode (
    .instr     (in_instr),
    .rmask     (new_entry_s.rmask),
    .wmask     (new_entry_s.wmask),
    .is_branch (new_entry_s.is_branch),
    .is_load   (new_entry_s.is_load),
    .is_store  (new_entry_s.is_store)
  );

`ifdef FRONTEND_HOIST_EN
  // Lowest load in the window that commutes with every older entry.
  always_comb begin
    logic blocked;
    sel_idx_s = '0;
    hoist_s   = 1'b0;
    for (int i = 1; i < DEPTH; i++) begin
      blocked = 1'b0;
      for (int j = 0; j < DEPTH; j++) begin
        blocked = blocked | ((j < i) &&
                  (entry_r[j].is_branch || entry_r[j].is_store ||
                   ((entry_r[i].wmask & (entry_r[j].rmask | entry_r[j].wmask)) != '0) ||
                   ((entry_r[j].wmask & entry_r[i].rmask) != '0)));
      end
      if (!hoist_s && (i < WINDOW) && (i < int'(count_r)) && entry_r[i].is_load && !blocked) begin
        hoist_s   = 1'b1;
        sel_idx_s = IW'(i);
      end else begin
        hoist_s   = hoist_s;
      end
    end
  end
`else
  logic unused_hoist_s;

  // Strict in-order issue; dependency fields only matter when hoisting.
  always_comb begin
    sel_idx_s      = '0;
    hoist_s        = 1'b0;
    unused_hoist_s = (WINDOW == 0);
    for (int k = 0; k < DEPTH; k++) begin
      unused_hoist_s = unused_hoist_s ^ (^{entry_r[k].rmask, entry_r[k].wmask,
                                           entry_r[k].is_load, entry_r[k].is_store});
    end
  end
`endif

  assign head_s       = entry_r[sel_idx_s];
  assign pred_idx_s   = ((state_r == ST_NORMAL) && (sel_idx_s == '0)) ? IW'(1) : '0;
  assign pred_entry_s = entry_r[pred_idx_s];
  assign count        = count_r;

  // Issue slot and predictor view, driven only from registered state.
  always_comb begin
    out_valid   = 1'b0;
    out_nop     = 1'b0;
    out_hoisted = 1'b0;
    out_pc      = 32'd0;
    out_instr   = 32'd0;
    pred_valid  = count_r > CW'(pred_idx_s);
    pred_pc     = pred_valid ? pred_entry_s.pc : 32'd0;
    pred_instr  = pred_valid ? pred_entry_s.instr : 32'd0;
    if (state_r == ST_BUBBLE) begin
      out_valid = 1'b1;
      out_nop   = 1'b1;
    end else if (count_r != '0) begin
      out_valid   = 1'b1;
      out_hoisted = hoist_s;
      out_pc      = head_s.pc;
      out_instr   = head_s.instr;
    end else begin
      out_valid   = 1'b0;
    end
  end

  assign in_ready = (count_r < CW'(DEPTH)) && !flush;
  assign enq_s    = in_valid && in_ready;
  assign issue_s  = (state_r == ST_NORMAL) && (count_r != '0) && out_ready;

  // Remove the issued entry by shifting younger ones down, then append.
  always_comb begin
    for (int k = 0; k < DEPTH - 1; k++) begin
      entry_nxt_s[k] = (issue_s && (IW'(k) >= sel_idx_s)) ? entry_r[k + 1] : entry_r[k];
    end
    entry_nxt_s[DEPTH - 1] = entry_r[DEPTH - 1];
    count_shift_s = count_r - (issue_s ? CW'(1) : CW'(0));
    if (enq_s) begin
      entry_nxt_s[count_shift_s[IW-1:0]] = new_entry_s;
    end else begin
      entry_nxt_s[DEPTH - 1] = entry_nxt_s[DEPTH - 1];
    end
    count_nxt_s = count_shift_s + (enq_s ? CW'(1) : CW'(0));
  end

  // Bubble sequencing; a flush always returns to normal issue.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_NORMAL: state_nxt_s = (issue_s && head_s.is_branch) ? ST_BUBBLE : ST_NORMAL;
      ST_BUBBLE: state_nxt_s = out_ready ? ST_NORMAL : ST_BUBBLE;
      default:   state_nxt_s = ST_NORMAL;
    endcase
    if (flush) begin
      state_nxt_s = ST_NORMAL;
    end else begin
      state_nxt_s = state_nxt_s;
    end
  end

  // Queue storage, occupancy and issue state.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      count_r <= '0;
      state_r <= ST_NORMAL;
      for (int k = 0; k < DEPTH; k++) begin
        entry_r[k] <= '0;
      end
    end else if (flush) begin
      count_r <= '0;
      state_r <= ST_NORMAL;
      for (int k = 0; k < DEPTH; k++) begin
        entry_r[k] <= '0;
      end
    end else begin
      count_r <= count_nxt_s;
      state_r <= state_nxt_s;
      for (int k = 0; k < DEPTH; k++) begin
        entry_r[k] <= entry_nxt_s[k];
      end
    end
  end

endmodule
